// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32I pipeline: load-use stalls, branch flushes,
// data-memory freeze with a timeout watchdog, and saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Instruc_IFID,
  input  logic [4:0]        rd_IDEX,
  input  logic              memRead_IDEX,
  input  logic              branch_taken_EX,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              cnt_clr,
  output logic              pc_write,
  output logic              IFID_write,
  output logic              IFID_flush,
  output logic              control_mux_sel,
  output logic              pipe_freeze,
  output logic              fault,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [15:0]      LP_WAIT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX   = '1;

  state_t           r_state;
  logic [15:0]      r_waitCnt;
  logic             r_fault;
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushCount;

  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_usesRs1;
  logic       w_usesRs2;
  logic       w_loadUse;
  logic       w_memBusy;
  logic       w_stallInc;
  logic       w_flushInc;
  logic       w_unused;

  assign w_opcode = Instruc_IFID[6:0];
  assign w_rs1    = Instruc_IFID[19:15];
  assign w_rs2    = Instruc_IFID[24:20];
  assign w_unused = ^{Instruc_IFID[31:25], Instruc_IFID[14:7]};

  always_comb begin
    w_usesRs1 = 1'b0;
    w_usesRs2 = 1'b0;
    case (w_opcode)
      7'b0110011: begin w_usesRs1 = 1'b1; w_usesRs2 = 1'b1; end
      7'b0100011: begin w_usesRs1 = 1'b1; w_usesRs2 = 1'b1; end
      7'b1100011: begin w_usesRs1 = 1'b1; w_usesRs2 = 1'b1; end
      7'b0010011: w_usesRs1 = 1'b1;
      7'b0000011: w_usesRs1 = 1'b1;
      7'b1100111: w_usesRs1 = 1'b1;
      default: ;
    endcase
  end

  assign w_loadUse = memRead_IDEX && (rd_IDEX != 5'd0) &&
                     ((w_usesRs1 && (rd_IDEX == w_rs1)) || (w_usesRs2 && (rd_IDEX == w_rs2)));
  assign w_memBusy = dmem_req && !dmem_ready;

  // Priority: memory freeze, then taken branch (squashes the load-use victim), then load-use.
  always_comb begin
    pc_write        = 1'b1;
    IFID_write      = 1'b1;
    IFID_flush      = 1'b0;
    control_mux_sel = 1'b0;
    pipe_freeze     = 1'b0;
    if (r_state == FAULT || w_memBusy) begin
      pc_write    = 1'b0;
      IFID_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (branch_taken_EX) begin
      IFID_flush      = 1'b1;
      control_mux_sel = 1'b1;
    end else if (w_loadUse) begin
      pc_write        = 1'b0;
      IFID_write      = 1'b0;
      control_mux_sel = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_waitCnt <= 16'd0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_memBusy) begin
            if (MEM_TIMEOUT == 1) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state   <= MEM_WAIT;
              r_waitCnt <= 16'd1;
            end
          end
        end
        MEM_WAIT: begin
          if (!w_memBusy) begin
            r_state   <= RUN;
            r_waitCnt <= 16'd0;
          end else if (r_waitCnt == LP_WAIT_LAST) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end
        FAULT:   r_fault <= 1'b1;
        default: r_state <= RUN;
      endcase
    end
  end

  assign w_stallInc = (r_state != FAULT) && (w_memBusy || (w_loadUse && !branch_taken_EX));
  assign w_flushInc = (r_state != FAULT) && branch_taken_EX && !w_memBusy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else if (cnt_clr) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      if (w_stallInc && r_stallCycles != LP_CNT_MAX) r_stallCycles <= r_stallCycles + CNT_W'(1);
      if (w_flushInc && r_flushCount != LP_CNT_MAX)  r_flushCount  <= r_flushCount + CNT_W'(1);
    end
  end

  assign state        = r_state;
  assign fault        = r_fault;
  assign stall_cycles = r_stallCycles;
  assign flush_count  = r_flushCount;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// checked against a behavioural model built from streak counts and saturating integers.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNTW    = 3;
  localparam int CNTMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     instr = 32'h0000_0013;
  logic [4:0]      rdIdex = 5'd0;
  logic            memRead = 1'b0;
  logic            branch = 1'b0;
  logic            dmemReq = 1'b0;
  logic            dmemReady = 1'b0;
  logic            cntClr = 1'b0;
  logic            pcWrite, ifidWrite, ifidFlush, ctrlMux, freeze, faultOut;
  logic [1:0]      stateOut;
  logic [CNTW-1:0] stallCycles, flushCount;

  pipeline_hazard_ctrl #(.CNT_W(CNTW), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .Instruc_IFID(instr), .rd_IDEX(rdIdex),
    .memRead_IDEX(memRead), .branch_taken_EX(branch), .dmem_req(dmemReq),
    .dmem_ready(dmemReady), .cnt_clr(cntClr), .pc_write(pcWrite),
    .IFID_write(ifidWrite), .IFID_flush(ifidFlush), .control_mux_sel(ctrlMux),
    .pipe_freeze(freeze), .fault(faultOut), .state(stateOut),
    .stall_cycles(stallCycles), .flush_count(flushCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pcW, ifW, flush, mux, frz, flt, st, stall, fl, cyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Model state: consecutive busy-cycle streak, sticky fault, saturating counters.
  int mStreak = 0;
  bit mFault  = 1'b0;
  int mStall  = 0;
  int mFlush  = 0;

  localparam logic [6:0] OP_R = 7'h33, OP_IMM = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23,
                         OP_BR = 7'h63, OP_JALR = 7'h67, OP_LUI = 7'h37, OP_AUIPC = 7'h17,
                         OP_JAL = 7'h6F, OP_BAD = 7'h7F;

  function automatic logic [31:0] mkInstr(logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, 5'd9, op};
  endfunction

  task automatic checkOutput(string name, int act, int want, int cyc);
    checks++;
    if (act != want) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, push the model's expectation, then
  // advance the model across the following rising edge.
  task automatic applyStimulus(bit r, logic [31:0] ins, logic [4:0] rd, bit mr, bit br,
                               bit rq, bit rdy, bit clr);
    exp_t e;
    logic [6:0] op;
    bit u1, u2, lu, busy;
    @(negedge clk);
    rst = r; instr = ins; rdIdex = rd; memRead = mr; branch = br;
    dmemReq = rq; dmemReady = rdy; cntClr = clr;
    if (r) begin
      mStreak = 0; mFault = 1'b0; mStall = 0; mFlush = 0;
    end
    op   = ins[6:0];
    u1   = op inside {OP_R, OP_IMM, OP_LD, OP_ST, OP_BR, OP_JALR};
    u2   = op inside {OP_R, OP_ST, OP_BR};
    lu   = mr && rd != 0 && ((u1 && rd == ins[19:15]) || (u2 && rd == ins[24:20]));
    busy = rq && !rdy;
    e.cyc   = cycle;
    e.st    = mFault ? 2 : (mStreak > 0 ? 1 : 0);
    e.flt   = mFault ? 1 : 0;
    e.stall = mStall;
    e.fl    = mFlush;
    if (mFault || busy)  begin e.pcW = 0; e.ifW = 0; e.flush = 0; e.mux = 0; e.frz = 1; end
    else if (br)         begin e.pcW = 1; e.ifW = 1; e.flush = 1; e.mux = 1; e.frz = 0; end
    else if (lu)         begin e.pcW = 0; e.ifW = 0; e.flush = 0; e.mux = 1; e.frz = 0; end
    else                 begin e.pcW = 1; e.ifW = 1; e.flush = 0; e.mux = 0; e.frz = 0; end
    expQ.push_back(e);
    if (!r) begin
      if (clr) begin
        mStall = 0; mFlush = 0;
      end else if (!mFault) begin
        if (busy || (lu && !br)) mStall = (mStall < CNTMAX) ? mStall + 1 : CNTMAX;
        if (br && !busy)         mFlush = (mFlush < CNTMAX) ? mFlush + 1 : CNTMAX;
      end
      if (!mFault) begin
        mStreak = busy ? mStreak + 1 : 0;
        if (mStreak >= TIMEOUT) mFault = 1'b1;
      end
    end
    cycle++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(0, mkInstr(OP_IMM, 0, 0), 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare 2 time units after the drive edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc_write",        int'(pcWrite),     e.pcW,   e.cyc);
        checkOutput("IFID_write",      int'(ifidWrite),   e.ifW,   e.cyc);
        checkOutput("IFID_flush",      int'(ifidFlush),   e.flush, e.cyc);
        checkOutput("control_mux_sel", int'(ctrlMux),     e.mux,   e.cyc);
        checkOutput("pipe_freeze",     int'(freeze),      e.frz,   e.cyc);
        checkOutput("fault",           int'(faultOut),    e.flt,   e.cyc);
        checkOutput("state",           int'(stateOut),    e.st,    e.cyc);
        checkOutput("stall_cycles",    int'(stallCycles), e.stall, e.cyc);
        checkOutput("flush_count",     int'(flushCount),  e.fl,    e.cyc);
      end
    end
  end

  initial begin
    logic [6:0] opList [10];
    logic [6:0] op;
    opList = '{OP_R, OP_IMM, OP_LD, OP_ST, OP_BR, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL, OP_BAD};

    $display("[TB] reset with busy inputs");
    applyStimulus(1, mkInstr(OP_R, 5, 5), 5, 1, 1, 1, 0, 0);
    applyStimulus(1, mkInstr(OP_R, 5, 5), 5, 1, 1, 1, 0, 0);
    idle(2);

    $display("[TB] load-use matrix");
    applyStimulus(0, mkInstr(OP_R, 1, 5), 5, 1, 0, 0, 0, 0);
    idle(1);
    applyStimulus(0, mkInstr(OP_IMM, 3, 5), 5, 1, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_R, 0, 2), 0, 1, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_ST, 2, 5), 5, 1, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_LUI, 5, 5), 5, 1, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_JALR, 5, 0), 5, 1, 0, 0, 0, 1);
    idle(1);

    $display("[TB] branch with coincident load-use");
    applyStimulus(0, mkInstr(OP_BR, 5, 6), 5, 1, 1, 0, 0, 0);
    idle(1);
    applyStimulus(0, mkInstr(OP_IMM, 0, 0), 0, 0, 0, 0, 0, 1);

    $display("[TB] memory wait with branch held");
    for (int i = 0; i < 3; i++) applyStimulus(0, mkInstr(OP_IMM, 0, 0), 0, 0, 1, 1, 0, 0);
    applyStimulus(0, mkInstr(OP_IMM, 0, 0), 0, 0, 1, 1, 1, 0);
    idle(2);

    $display("[TB] watchdog timeout");
    for (int i = 0; i < 5; i++) applyStimulus(0, mkInstr(OP_R, 1, 1), 1, 1, 1, 1, 0, 0);
    applyStimulus(0, mkInstr(OP_IMM, 0, 0), 0, 0, 0, 1, 1, 0);
    applyStimulus(0, mkInstr(OP_IMM, 0, 0), 0, 0, 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_IMM, 0, 0), 0, 0, 0, 0, 0, 0);
    idle(2);

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < 9; i++) applyStimulus(0, mkInstr(OP_LD, 7, 0), 7, 1, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_LD, 7, 0), 7, 1, 0, 0, 0, 1);
    applyStimulus(0, mkInstr(OP_LD, 7, 0), 7, 1, 0, 0, 0, 0);
    idle(1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      op = opList[$urandom_range(0, 9)];
      applyStimulus($urandom_range(0, 29) == 0,
                    mkInstr(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    end
    idle(1);

    repeat (3) @(negedge clk);
    #3;
    checkOutput("scoreboard_drained", expQ.size(), 0, cycle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
